// File: rtl/sfp_neuron_mac.sv
`default_nettype none
// ============================================================================
// Module   : sfp_neuron_mac
// Brief    : Single-neuron Q32.32 multiply-accumulate stage. It streams
//            N_INPUTS (x, w) beats, accumulates them with saturation, adds a
//            bias and applies a hard activation. One result per vector is
//            presented on a valid/ready output.
// Revision : 1.0  initial release
// ============================================================================
module sfp_neuron_mac #(
    parameter int N_INPUTS = 4,
    parameter int CNT_W    = $clog2(N_INPUTS + 1)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  act,
    input  logic [63:0] bias,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_x,
    input  logic [63:0] in_w,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_y,
    output logic [63:0] out_sum,
    output logic        out_sat
);

    // Q32.32 constants used by the activation functions
    localparam logic signed [63:0] c_ONE     = 64'sh0000_0001_0000_0000;
    localparam logic signed [63:0] c_NEG_ONE = 64'shFFFF_FFFF_0000_0000;
    localparam logic signed [63:0] c_HALF    = 64'sh0000_0000_8000_0000;
    localparam logic signed [63:0] c_TWO     = 64'sh0000_0002_0000_0000;
    localparam logic signed [63:0] c_NEG_TWO = 64'shFFFF_FFFE_0000_0000;
    localparam logic [63:0]        c_POS_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0]        c_NEG_MAX = 64'h8000_0000_0000_0000;
    localparam logic [CNT_W-1:0]   c_LAST    = CNT_W'(N_INPUTS - 1);

    // Activation select encoding
    localparam logic [1:0] c_ACT_STEP    = 2'd0;
    localparam logic [1:0] c_ACT_SIGMOID = 2'd1;
    localparam logic [1:0] c_ACT_TANH    = 2'd2;

    typedef enum logic [1:0] {
        S_ACC  = 2'd0,
        S_BIAS = 2'd1,
        S_ACT  = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [CNT_W-1:0]      r_count;
    logic signed [63:0]    r_acc;
    logic                  r_sat;
    logic [1:0]            r_act;
    logic [63:0]           r_bias;

    logic                  w_beat;
    logic                  w_first;
    logic                  w_last;
    logic signed [127:0]   w_x_ext;
    logic signed [127:0]   w_w_ext;
    logic signed [127:0]   w_prod;
    logic [63:0]           w_prod_q;
    logic [63:0]           w_acc_prior;
    logic                  w_sat_prior;
    logic [64:0]           w_acc_add;
    logic [64:0]           w_bias_add;
    logic [63:0]           w_act_y;

    // Two's-complement add that clamps to the extreme value on overflow.
    // Bit 64 of the result flags that a clamp happened.
    function automatic logic [64:0] sat_add(input logic [63:0] a, input logic [63:0] b);
        logic [63:0] s;
        logic        ovf;
        s   = a + b;
        ovf = (a[63] == b[63]) && (s[63] != a[63]);
        if (ovf) begin
            s = a[63] ? c_NEG_MAX : c_POS_MAX;
        end
        return {ovf, s};
    endfunction

    assign in_ready = (r_state == S_ACC);
    assign w_beat   = in_valid && in_ready;
    assign w_first  = (r_count == '0);
    assign w_last   = (r_count == c_LAST);

    // Full-precision product, rescaled back to Q32.32 with wrap-around
    assign w_x_ext  = {{64{in_x[63]}}, in_x};
    assign w_w_ext  = {{64{in_w[63]}}, in_w};
    assign w_prod   = w_x_ext * w_w_ext;
    assign w_prod_q = 64'(w_prod >>> 32);

    // The first beat of a vector starts from a clean accumulator
    assign w_acc_prior = w_first ? 64'd0 : r_acc;
    assign w_sat_prior = w_first ? 1'b0 : r_sat;
    assign w_acc_add   = sat_add(w_acc_prior, w_prod_q);
    assign w_bias_add  = sat_add(r_acc, r_bias);

    // Hard activation of the biased sum
    always_comb begin
        w_act_y = '0;
        case (r_act)
            c_ACT_STEP: begin
                w_act_y = r_acc[63] ? 64'd0 : c_ONE;
            end
            c_ACT_SIGMOID: begin
                if (r_acc >= c_TWO) begin
                    w_act_y = c_ONE;
                end else if (r_acc <= c_NEG_TWO) begin
                    w_act_y = 64'd0;
                end else begin
                    w_act_y = c_HALF + (r_acc >>> 2);
                end
            end
            c_ACT_TANH: begin
                if (r_acc > c_ONE) begin
                    w_act_y = c_ONE;
                end else if (r_acc < c_NEG_ONE) begin
                    w_act_y = c_NEG_ONE;
                end else begin
                    w_act_y = r_acc;
                end
            end
            default: begin
                w_act_y = r_acc[63] ? 64'd0 : r_acc;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_ACC;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode: accumulate, add bias, activate, hold until accepted
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_ACC:  if (w_beat && w_last) w_state_next = S_BIAS;
            S_BIAS: w_state_next = S_ACT;
            S_ACT:  w_state_next = S_OUT;
            S_OUT:  if (out_valid && out_ready) w_state_next = S_ACC;
            default: w_state_next = S_ACC;
        endcase
    end

    // Datapath: accumulator, sticky saturation flag and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count   <= '0;
            r_acc     <= '0;
            r_sat     <= 1'b0;
            r_act     <= '0;
            r_bias    <= '0;
            out_valid <= 1'b0;
            out_y     <= '0;
            out_sum   <= '0;
            out_sat   <= 1'b0;
        end else begin
            case (r_state)
                S_ACC: begin
                    if (w_beat) begin
                        // act/bias are frozen for the whole vector on its first beat
                        if (w_first) begin
                            r_act  <= act;
                            r_bias <= bias;
                        end
                        r_acc   <= w_acc_add[63:0];
                        r_sat   <= w_sat_prior | w_acc_add[64];
                        r_count <= w_last ? '0 : r_count + CNT_W'(1);
                    end
                end
                S_BIAS: begin
                    r_acc <= w_bias_add[63:0];
                    r_sat <= r_sat | w_bias_add[64];
                end
                S_ACT: begin
                    out_y     <= w_act_y;
                    out_sum   <= r_acc;
                    out_sat   <= r_sat;
                    out_valid <= 1'b1;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_acc     <= '0;
                        r_sat     <= 1'b0;
                    end
                end
                default: begin
                    r_count <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
